// File: rtl/dvs_pkg.sv
// Shared constants and types for the DVS time-surface blocks.
// The timestamp BRAM is GRID_W x GRID_W cells of TS_W bits each.
package dvs_pkg;

  localparam int GRID_W  = 16;
  localparam int N_CELLS = GRID_W * GRID_W;
  localparam int TS_W    = 16;

  // Marks a cell that has never been written by the event writer.
  localparam logic [TS_W-1:0] TS_EMPTY = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    EMIT
  } scan_state_t;

endpackage

// File: rtl/ts_recency_quant.sv
// Converts one stored timestamp into a recency feature relative to t_ref.
// Newest cells map to FEAT_MAX; empty, future or stale cells map to 0.
module ts_recency_quant
  import dvs_pkg::*;
#(
  parameter int AGE_SHIFT = 6,
  parameter int FEAT_W    = 4
) (
  input  logic [TS_W-1:0]   ts,
  input  logic [TS_W-1:0]   t_ref,
  output logic [FEAT_W-1:0] feature
);

  localparam logic [TS_W-1:0] FEAT_MAX = TS_W'((1 << FEAT_W) - 1);

  logic [TS_W-1:0] age;
  logic [TS_W-1:0] q;

  // Modulo-2^16 subtraction keeps the age correct across counter wrap;
  // a set MSB means the timestamp lies in the future or is too old.
  always_comb begin
    age     = t_ref - ts;
    q       = age >> AGE_SHIFT;
    feature = '0;
    if (ts != TS_EMPTY && !age[TS_W-1] && q < FEAT_MAX) begin
      feature = FEAT_MAX[FEAT_W-1:0] - q[FEAT_W-1:0];
    end
  end

endmodule

// File: rtl/time_surface_scanner.sv
// Walks all cells of the timestamp BRAM once per start and streams
// recency features to the classifier, counting the active cells.
module time_surface_scanner
  import dvs_pkg::*;
#(
  parameter int AGE_SHIFT = 6,
  parameter int FEAT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cur_time,
  output logic              busy,
  output logic              done,
  output logic [7:0]        bram_addr,
  input  logic [15:0]       bram_dout,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [FEAT_W-1:0] feat_data,
  output logic [7:0]        feat_idx,
  output logic              feat_last,
  output logic [8:0]        active_count
);

  localparam logic [7:0] LAST_IDX = 8'(N_CELLS - 1);

  scan_state_t       state;
  scan_state_t       next_state;
  logic [TS_W-1:0]   t_ref;
  logic [FEAT_W-1:0] feature;
  logic              handshake;

  assign handshake = feat_valid & feat_ready;

  ts_recency_quant #(
    .AGE_SHIFT (AGE_SHIFT),
    .FEAT_W    (FEAT_W)
  ) u_quant (
    .ts      (bram_dout),
    .t_ref   (t_ref),
    .feature (feature)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RD1;
      RD1:  next_state = RD2;
      RD2:  next_state = EMIT;
      EMIT: if (handshake) next_state = feat_last ? IDLE : RD1;
      default: next_state = IDLE;
    endcase
  end

  // RD1 is the BRAM's read cycle; the feature is captured one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_ref        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bram_addr    <= '0;
      feat_valid   <= 1'b0;
      feat_data    <= '0;
      feat_idx     <= '0;
      feat_last    <= 1'b0;
      active_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t_ref        <= cur_time;
            bram_addr    <= '0;
            active_count <= '0;
            busy         <= 1'b1;
          end
        end
        RD2: begin
          feat_data  <= feature;
          feat_idx   <= bram_addr;
          feat_last  <= (bram_addr == LAST_IDX);
          feat_valid <= 1'b1;
          if (feature != '0) begin
            active_count <= active_count + 9'd1;
          end
        end
        EMIT: begin
          if (handshake) begin
            feat_valid <= 1'b0;
            if (feat_last) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              bram_addr <= bram_addr + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_surface_scanner.sv
// Randomised bench for time_surface_scanner with a BRAM model and a
// scan-level reference model checked on every falling edge.
module tb_time_surface_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cur_time;
  logic        busy;
  logic        done;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout;
  logic        feat_valid;
  logic        feat_ready;
  logic [3:0]  feat_data;
  logic [7:0]  feat_idx;
  logic        feat_last;
  logic [8:0]  active_count;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;
  int duty = 100;
  int stall_idx = -1;
  bit check_en = 0;

  // Reference model state
  bit m_busy = 0;
  bit m_done = 0;
  bit m_stalled = 0;
  bit m_first = 0;
  int m_next = 0;
  int m_active = 0;
  int since = 0;
  int words = 0;
  int last_seen = 0;
  int done_edge = -1;
  int exp_feat [256];
  int got [256];
  logic [3:0] hold_data;
  logic [7:0] hold_idx;
  logic       hold_last;

  time_surface_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cur_time     (cur_time),
    .busy         (busy),
    .done         (done),
    .bram_addr    (bram_addr),
    .bram_dout    (bram_dout),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .feat_data    (feat_data),
    .feat_idx     (feat_idx),
    .feat_last    (feat_last),
    .active_count (active_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) bram_dout <= mem[bram_addr];

  function automatic int ref_feat(input int ts, input int tr);
    int age;
    int q;
    if (ts == 32768) return 0;
    age = (tr - ts + 65536) % 65536;
    if (age >= 32768) return 0;
    q = age / 64;
    if (q >= 15) return 0;
    return 15 - q;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] t);
    @(posedge clk);
    #1;
    start = 1;
    cur_time = t;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
    #1;
    checkOutput("done_timeout", ok, 1);
  endtask

  task automatic fill_empty();
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
  endtask

  task automatic fill_random(input logic [15:0] t);
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) mem[i] = 16'h8000;
      else if (r < 30) mem[i] = 16'(int'(t) + $urandom_range(1, 500));
      else mem[i] = 16'(int'(t) - $urandom_range(0, 1100));
      if (mem[i] == 16'h8000 && r >= 20) mem[i] = 16'h8001;
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", feat_valid, 0);
    checkOutput("rst_last", feat_last, 0);
    checkOutput("rst_addr", bram_addr, 0);
    checkOutput("rst_data", feat_data, 0);
    checkOutput("rst_idx", feat_idx, 0);
    checkOutput("rst_active", active_count, 0);
  endtask

  // Consumer: random ready, optionally refusing one particular index
  initial begin
    feat_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_idx >= 0 && feat_valid === 1'b1 && int'(feat_idx) == stall_idx) feat_ready = 0;
      else feat_ready = ($urandom_range(0, 99) < duty);
    end
  end

  // Compare process: check what the last rising edge produced, then advance the model
  always @(negedge clk) begin
    if (check_en) begin
      since++;
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      if (m_done) begin
        checkOutput("active_count", active_count, m_active);
        done_edge = since;
      end
      if (m_stalled) begin
        checkOutput("stall_valid", feat_valid, 1);
        checkOutput("stall_data", feat_data, hold_data);
        checkOutput("stall_idx", feat_idx, hold_idx);
        checkOutput("stall_last", feat_last, hold_last);
      end
      if (!m_busy) begin
        checkOutput("valid_idle", feat_valid, 0);
      end else if (feat_valid === 1'b1) begin
        if (m_first) begin
          checkOutput("valid_latency", since, 2);
          m_first = 0;
        end
        checkOutput("feat_idx", feat_idx, m_next);
        checkOutput("feat_data", feat_data, exp_feat[m_next]);
        checkOutput("feat_last", feat_last, m_next == 255);
      end

      m_done = 0;
      if (rst) begin
        m_busy = 0;
        m_stalled = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_first = 1;
          m_next = 0;
          m_active = 0;
          since = -1;
          words = 0;
          last_seen = 0;
          for (int i = 0; i < 256; i++) begin
            exp_feat[i] = ref_feat(int'(mem[i]), int'(cur_time));
            got[i] = -1;
            if (exp_feat[i] != 0) m_active++;
          end
        end
      end else if (feat_valid === 1'b1 && feat_ready) begin
        got[m_next] = int'(feat_data);
        words++;
        if (feat_last) last_seen++;
        m_stalled = 0;
        if (m_next == 255) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_next++;
        end
      end else if (feat_valid === 1'b1) begin
        m_stalled = 1;
        hold_data = feat_data;
        hold_idx = feat_idx;
        hold_last = feat_last;
      end
    end
  end

  initial begin
    rst = 1;
    start = 0;
    cur_time = 0;
    fill_empty();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_reset_values();
    check_en = 1;

    // Empty memory, full throughput
    duty = 100;
    applyStimulus(16'h1234);
    wait_done(2000);
    checkOutput("t1_done_edge", done_edge, 768);
    checkOutput("t1_active", active_count, 0);
    checkOutput("t1_words", words, 256);
    checkOutput("t1_last_count", last_seen, 1);

    // Two recent cells
    fill_empty();
    mem[5] = 16'd1000;
    mem[6] = 16'd808;
    applyStimulus(16'd1000);
    wait_done(2000);
    checkOutput("t2_idx5", got[5], 15);
    checkOutput("t2_idx6", got[6], 12);
    checkOutput("t2_idx7", got[7], 0);
    checkOutput("t2_active", active_count, 2);

    // Counter wrap-around and future timestamps
    fill_empty();
    mem[0] = 16'hFFF0;
    mem[1] = 16'h0020;
    applyStimulus(16'h0010);
    wait_done(2000);
    checkOutput("t3_wrap", got[0], 15);
    checkOutput("t3_future", got[1], 0);
    checkOutput("t3_active", active_count, 1);

    // Backpressure with sparse ready
    duty = 30;
    fill_random(16'd20000);
    applyStimulus(16'd20000);
    wait_done(20000);
    checkOutput("t4_words", words, 256);

    // Start and cur_time disturbances mid-scan
    duty = 70;
    fill_random(16'd5000);
    applyStimulus(16'd5000);
    repeat (150) @(posedge clk);
    applyStimulus(16'd40000);
    cur_time = 16'd123;
    wait_done(20000);
    checkOutput("t5_words", words, 256);
    repeat (5) @(negedge clk);
    checkOutput("t5_idle_busy", busy, 0);

    // Reset while stalled on index 100
    duty = 100;
    stall_idx = 100;
    fill_random(16'd9000);
    applyStimulus(16'd9000);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (feat_valid === 1'b1 && feat_idx == 8'd100) hit = 1;
      end
      checkOutput("t6_reach_100", hit, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    #1;
    check_reset_values();
    stall_idx = -1;
    repeat (4) @(negedge clk);
    applyStimulus(16'd9000);
    wait_done(2000);
    checkOutput("t6_words", words, 256);
    checkOutput("t6_last_count", last_seen, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
